// File: rtl/img_pixel_fetch.sv
// Pixel-source stage: maps hcount/vcount into a scaled, movable image window,
// fetches RGB332 pixels from a synchronous ROM and aligns sync/blank with the colour.
module img_pixel_fetch #(
    parameter int          SCREEN_WIDTH  = 640,
    parameter int          SCREEN_HEIGHT = 480,
    parameter int          COLOR_DEPTH   = 8,
    parameter int          IMG_W         = 160,
    parameter int          IMG_H         = 120,
    parameter int          SCALE_LOG2    = 1,
    parameter int          ROM_LATENCY   = 2,
    parameter int          ADDR_W        = 15,
    parameter logic [23:0] BG_COLOR      = 24'h202020
) (
    input  logic                   vga_clk,
    input  logic                   reset_n,
    input  logic [9:0]             hcount,
    input  logic [9:0]             vcount,
    input  logic                   hs_in,
    input  logic                   vs_in,
    input  logic                   blank_n_in,
    input  logic                   img_en,
    input  logic [9:0]             x_off,
    input  logic [9:0]             y_off,
    output logic [ADDR_W-1:0]      rom_addr,
    output logic                   rom_rd,
    input  logic [7:0]             rom_data,
    output logic [COLOR_DEPTH-1:0] vga_r,
    output logic [COLOR_DEPTH-1:0] vga_g,
    output logic [COLOR_DEPTH-1:0] vga_b,
    output logic                   vga_hs,
    output logic                   vga_vs,
    output logic                   vga_blank_n,
    output logic                   frame_start
);

    localparam int          PW       = ROM_LATENCY + 1;
    localparam logic [10:0] WIN_W    = 11'(IMG_W << SCALE_LOG2);
    localparam logic [10:0] WIN_H    = 11'(IMG_H << SCALE_LOG2);
    localparam logic [10:0] SUB_MASK = 11'((1 << SCALE_LOG2) - 1);
    localparam logic [10:0] SCR_W    = 11'(SCREEN_WIDTH);
    localparam logic [10:0] SCR_H    = 11'(SCREEN_HEIGHT);

    function automatic logic [23:0] rgb332_expand(input logic [7:0] d);
        rgb332_expand = {d[7:5], d[7:5], d[7:6],
                         d[4:2], d[4:2], d[4:3],
                         d[1:0], d[1:0], d[1:0], d[1:0]};
    endfunction

    logic              en_l_r;
    logic [9:0]        x_l_r;
    logic [9:0]        y_l_r;
    logic              synced_r;
    logic              frame_start_r;
    logic [ADDR_W-1:0] row_base_r;
    logic [10:0]       col_pix_r;
    logic [ADDR_W-1:0] rom_addr_r;
    logic [PW-1:0]     win_pipe_r;
    logic [PW-1:0]     hs_pipe_r;
    logic [PW-1:0]     vs_pipe_r;
    logic [PW-1:0]     blank_pipe_r;
    logic [23:0]       color_r;
    logic              vga_hs_r;
    logic              vga_vs_r;
    logic              vga_blank_r;

    logic              fs_s;
    logic              en_s;
    logic [9:0]        x_s;
    logic [9:0]        y_s;
    logic [10:0]       h_s;
    logic [10:0]       v_s;
    logic [10:0]       x_end_s;
    logic [10:0]       y_end_s;
    logic [10:0]       vy_s;
    logic              h_in_s;
    logic              v_in_s;
    logic              in_win_s;
    logic [ADDR_W-1:0] row_cur_s;
    logic [10:0]       col_cur_s;
    logic [ADDR_W-1:0] addr_s;
    logic [23:0]       color_s;

    // Window test; the frame-start cycle already sees the new offsets/enable
    always_comb begin
        fs_s = (hcount == 10'd0) && (vcount == 10'd0);
        if (fs_s) begin
            en_s = img_en;
            x_s  = x_off;
            y_s  = y_off;
        end else begin
            en_s = en_l_r;
            x_s  = x_l_r;
            y_s  = y_l_r;
        end
        h_s      = {1'b0, hcount};
        v_s      = {1'b0, vcount};
        x_end_s  = {1'b0, x_s} + WIN_W;
        y_end_s  = {1'b0, y_s} + WIN_H;
        h_in_s   = (h_s >= {1'b0, x_s}) && (h_s < x_end_s) && (h_s < SCR_W);
        v_in_s   = (v_s >= {1'b0, y_s}) && (v_s < y_end_s) && (v_s < SCR_H);
        in_win_s = (synced_r || fs_s) && en_s && blank_n_in && h_in_s && v_in_s;
    end

    // Row-base accumulator and column counter; the row base steps by IMG_W per source row
    always_comb begin
        vy_s      = v_s - {1'b0, y_s};
        row_cur_s = row_base_r;
        if (hcount == 10'd0) begin
            if (vcount == y_s) begin
                row_cur_s = {ADDR_W{1'b0}};
            end else if (v_in_s && ((vy_s & SUB_MASK) == 11'd0)) begin
                row_cur_s = row_base_r + ADDR_W'(IMG_W);
            end else begin
                row_cur_s = row_base_r;
            end
        end else begin
            row_cur_s = row_base_r;
        end
        if (hcount == x_s) begin
            col_cur_s = 11'd0;
        end else begin
            col_cur_s = col_pix_r;
        end
        addr_s = row_cur_s + ADDR_W'(col_cur_s >> SCALE_LOG2);
    end

    // Shadow registers, frame-start pulse and stage-0 address register
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            en_l_r        <= 1'b0;
            x_l_r         <= 10'd0;
            y_l_r         <= 10'd0;
            synced_r      <= 1'b0;
            frame_start_r <= 1'b0;
            row_base_r    <= {ADDR_W{1'b0}};
            col_pix_r     <= 11'd0;
            rom_addr_r    <= {ADDR_W{1'b0}};
        end else begin
            if (fs_s) begin
                en_l_r   <= img_en;
                x_l_r    <= x_off;
                y_l_r    <= y_off;
                synced_r <= 1'b1;
            end
            frame_start_r <= fs_s;
            row_base_r    <= row_cur_s;
            if (in_win_s) begin
                col_pix_r  <= col_cur_s + 11'd1;
                rom_addr_r <= addr_s;
            end else begin
                col_pix_r  <= col_cur_s;
                rom_addr_r <= rom_addr_r;
            end
        end
    end

    // Delay line covering stage 0 plus the ROM read latency
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            win_pipe_r   <= {PW{1'b0}};
            hs_pipe_r    <= {PW{1'b1}};
            vs_pipe_r    <= {PW{1'b1}};
            blank_pipe_r <= {PW{1'b0}};
        end else begin
            win_pipe_r   <= {win_pipe_r[PW-2:0], in_win_s};
            hs_pipe_r    <= {hs_pipe_r[PW-2:0], hs_in};
            vs_pipe_r    <= {vs_pipe_r[PW-2:0], vs_in};
            blank_pipe_r <= {blank_pipe_r[PW-2:0], blank_n_in};
        end
    end

    // Colour select: image pixel, background, or black during blanking
    always_comb begin
        color_s = 24'h000000;
        if (!blank_pipe_r[PW-1]) begin
            color_s = 24'h000000;
        end else if (win_pipe_r[PW-1]) begin
            color_s = rgb332_expand(rom_data);
        end else begin
            color_s = BG_COLOR;
        end
    end

    // Output register stage for colour and the matching sync/blank
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            color_r     <= 24'h000000;
            vga_hs_r    <= 1'b1;
            vga_vs_r    <= 1'b1;
            vga_blank_r <= 1'b0;
        end else begin
            color_r     <= color_s;
            vga_hs_r    <= hs_pipe_r[PW-1];
            vga_vs_r    <= vs_pipe_r[PW-1];
            vga_blank_r <= blank_pipe_r[PW-1];
        end
    end

    assign rom_addr    = rom_addr_r;
    assign rom_rd      = win_pipe_r[0];
    assign vga_r       = color_r[23:16];
    assign vga_g       = color_r[15:8];
    assign vga_b       = color_r[7:0];
    assign vga_hs      = vga_hs_r;
    assign vga_vs      = vga_vs_r;
    assign vga_blank_n = vga_blank_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_img_pixel_fetch.sv
// Directed bench for img_pixel_fetch: compressed scan lines drive hcount/vcount,
// a two-cycle ROM model returns either the low address byte or a forced value.
module tb_img_pixel_fetch;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  hcount = 10'd0;
    logic [9:0]  vcount = 10'd0;
    logic        hs_in = 1'b1;
    logic        vs_in = 1'b1;
    logic        blank_n_in = 1'b0;
    logic        img_en = 1'b0;
    logic [9:0]  x_off = 10'd0;
    logic [9:0]  y_off = 10'd0;
    logic [14:0] rom_addr;
    logic        rom_rd;
    logic [7:0]  rom_data = 8'h00;
    logic [7:0]  rom_p1 = 8'h00;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic        frame_start;

    logic        force_en = 1'b0;
    logic [7:0]  force_val = 8'h00;
    int          tests_run = 0;
    int          tests_failed = 0;

    img_pixel_fetch dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
        .hs_in(hs_in), .vs_in(vs_in), .blank_n_in(blank_n_in), .img_en(img_en),
        .x_off(x_off), .y_off(y_off), .rom_addr(rom_addr), .rom_rd(rom_rd),
        .rom_data(rom_data), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .frame_start(frame_start)
    );

    always #5 vga_clk = ~vga_clk;

    // Synchronous ROM, data valid two clocks after the address
    always @(posedge vga_clk) begin
        rom_p1   <= force_en ? force_val : rom_addr[7:0];
        rom_data <= rom_p1;
    end

    task automatic drive_px(input int h, input int v);
        hcount     = h[9:0];
        vcount     = v[9:0];
        blank_n_in = (h < 640) && (v < 480);
        hs_in      = !((h >= 656) && (h < 752));
        vs_in      = !((v >= 490) && (v < 492));
        @(posedge vga_clk);
        #1;
    endtask

    task automatic lines(input int from, input int to);
        for (int v = from; v <= to; v++) drive_px(0, v);
    endtask

    task automatic new_frame(input logic en, input int x, input int y);
        img_en = en;
        x_off  = x[9:0];
        y_off  = y[9:0];
        drive_px(0, 0);
        lines(1, 50);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        for (int i = 0; i < 10; i++) drive_px(300, 100);
        tests_run++; if ({vga_r, vga_g, vga_b} !== 24'h000000) begin tests_failed++; $display("FAIL reset_rgb: got %h expected 000000", {vga_r, vga_g, vga_b}); end
        tests_run++; if (vga_hs !== 1'b1) begin tests_failed++; $display("FAIL reset_hs: got %b expected 1", vga_hs); end
        tests_run++; if (vga_vs !== 1'b1) begin tests_failed++; $display("FAIL reset_vs: got %b expected 1", vga_vs); end
        tests_run++; if (vga_blank_n !== 1'b0) begin tests_failed++; $display("FAIL reset_blank: got %b expected 0", vga_blank_n); end
        tests_run++; if (rom_rd !== 1'b0) begin tests_failed++; $display("FAIL reset_rd: got %b expected 0", rom_rd); end
        tests_run++; if (rom_addr !== 15'd0) begin tests_failed++; $display("FAIL reset_addr: got %0d expected 0", rom_addr); end
        tests_run++; if (frame_start !== 1'b0) begin tests_failed++; $display("FAIL reset_fs: got %b expected 0", frame_start); end
        reset_n = 1'b1;
        drive_px(301, 100);
    endtask

    task automatic test_frame_start;
        img_en = 1'b1; x_off = 10'd100; y_off = 10'd50;
        drive_px(0, 0);
        tests_run++; if (frame_start !== 1'b1) begin tests_failed++; $display("FAIL fs_pulse: got %b expected 1", frame_start); end
        drive_px(1, 0);
        tests_run++; if (frame_start !== 1'b0) begin tests_failed++; $display("FAIL fs_one_cycle: got %b expected 0", frame_start); end
    endtask

    task automatic test_latency;
        lines(1, 50);
        for (int h = 96; h <= 107; h++) begin
            drive_px(h, 50);
            if (h == 99) begin
                tests_run++; if (rom_rd !== 1'b0) begin tests_failed++; $display("FAIL rd_before_win: got %b expected 0", rom_rd); end
            end
            if (h == 100) begin
                tests_run++; if (rom_rd !== 1'b1) begin tests_failed++; $display("FAIL rd_first: got %b expected 1", rom_rd); end
                tests_run++; if (rom_addr !== 15'd0) begin tests_failed++; $display("FAIL addr_first: got %0d expected 0", rom_addr); end
            end
            if (h == 102) begin
                tests_run++; if (vga_r !== 8'h20) begin tests_failed++; $display("FAIL lat_bg: got %h expected 20", vga_r); end
            end
            if (h == 103) begin
                tests_run++; if ({vga_r, vga_g, vga_b} !== 24'h000000) begin tests_failed++; $display("FAIL lat_first_px: got %h expected 000000", {vga_r, vga_g, vga_b}); end
                tests_run++; if (vga_blank_n !== 1'b1) begin tests_failed++; $display("FAIL lat_blank: got %b expected 1", vga_blank_n); end
            end
            if (h == 105) begin
                tests_run++; if ({vga_r, vga_g, vga_b} !== 24'h000055) begin tests_failed++; $display("FAIL lat_addr1: got %h expected 000055", {vga_r, vga_g, vga_b}); end
            end
            if (h == 107) begin
                tests_run++; if (vga_b !== 8'hAA) begin tests_failed++; $display("FAIL lat_addr2: got %h expected aa", vga_b); end
            end
        end
        for (int h = 650; h <= 662; h++) begin
            drive_px(h, 50);
            if (h == 658) begin
                tests_run++; if (vga_hs !== 1'b1) begin tests_failed++; $display("FAIL hs_early: got %b expected 1", vga_hs); end
            end
            if (h == 659) begin
                tests_run++; if (vga_hs !== 1'b0) begin tests_failed++; $display("FAIL hs_fall: got %b expected 0", vga_hs); end
            end
            if (h == 662) begin
                tests_run++; if (vga_blank_n !== 1'b0) begin tests_failed++; $display("FAIL hs_blank: got %b expected 0", vga_blank_n); end
            end
        end
    endtask

    task automatic test_addressing;
        lines(51, 53);
        for (int h = 100; h <= 103; h++) drive_px(h, 53);
        tests_run++; if (rom_addr !== 15'd161) begin tests_failed++; $display("FAIL addr_161: got %0d expected 161", rom_addr); end
    endtask

    task automatic test_color;
        logic [7:0]  cv [5];
        logic [23:0] ce [5];
        cv = '{8'hE0, 8'h1C, 8'h03, 8'h00, 8'hB6};
        ce = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h000000, 24'hB6B6AA};
        drive_px(0, 54);
        force_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            force_val = cv[i];
            for (int k = 0; k < 6; k++) drive_px(150 + k, 54);
            tests_run++; if ({vga_r, vga_g, vga_b} !== ce[i]) begin tests_failed++; $display("FAIL color_%h: got %h expected %h", cv[i], {vga_r, vga_g, vga_b}, ce[i]); end
        end
        force_val = 8'hE0;
        for (int k = 0; k < 6; k++) drive_px(700 + k, 54);
        tests_run++; if ({vga_r, vga_g, vga_b} !== 24'h000000) begin tests_failed++; $display("FAIL color_blank: got %h expected 000000", {vga_r, vga_g, vga_b}); end
        force_en = 1'b0;
    endtask

    task automatic test_midframe_change;
        lines(55, 240);
        x_off = 10'd200;
        for (int h = 96; h <= 100; h++) drive_px(h, 240);
        tests_run++; if (rom_rd !== 1'b1) begin tests_failed++; $display("FAIL mid_rd: got %b expected 1", rom_rd); end
        tests_run++; if (rom_addr !== 15'd15200) begin tests_failed++; $display("FAIL mid_addr: got %0d expected 15200", rom_addr); end
    endtask

    task automatic test_window_end;
        lines(241, 289);
        for (int h = 100; h <= 423; h++) begin
            drive_px(h, 289);
            if (h == 419) begin
                tests_run++; if (rom_addr !== 15'd19199) begin tests_failed++; $display("FAIL addr_last: got %0d expected 19199", rom_addr); end
                tests_run++; if (rom_rd !== 1'b1) begin tests_failed++; $display("FAIL rd_last: got %b expected 1", rom_rd); end
            end
            if (h == 420) begin
                tests_run++; if (rom_rd !== 1'b0) begin tests_failed++; $display("FAIL rd_after: got %b expected 0", rom_rd); end
                tests_run++; if (rom_addr !== 15'd19199) begin tests_failed++; $display("FAIL addr_hold: got %0d expected 19199", rom_addr); end
            end
            if (h == 422) begin
                tests_run++; if ({vga_r, vga_g, vga_b} !== 24'hFFFFFF) begin tests_failed++; $display("FAIL last_px: got %h expected ffffff", {vga_r, vga_g, vga_b}); end
            end
            if (h == 423) begin
                tests_run++; if ({vga_r, vga_g, vga_b} !== 24'h202020) begin tests_failed++; $display("FAIL end_bg: got %h expected 202020", {vga_r, vga_g, vga_b}); end
            end
        end
    endtask

    task automatic test_next_frame;
        new_frame(1'b1, 200, 50);
        for (int h = 98; h <= 203; h++) begin
            drive_px(h, 50);
            if (h == 100) begin
                tests_run++; if (rom_rd !== 1'b0) begin tests_failed++; $display("FAIL nf_old_edge: got %b expected 0", rom_rd); end
            end
            if (h == 199) begin
                tests_run++; if (rom_rd !== 1'b0) begin tests_failed++; $display("FAIL nf_before: got %b expected 0", rom_rd); end
            end
            if (h == 200) begin
                tests_run++; if (rom_rd !== 1'b1 || rom_addr !== 15'd0) begin tests_failed++; $display("FAIL nf_start: got rd=%b addr=%0d expected rd=1 addr=0", rom_rd, rom_addr); end
            end
            if (h == 202) begin
                tests_run++; if (vga_r !== 8'h20) begin tests_failed++; $display("FAIL nf_bg: got %h expected 20", vga_r); end
            end
            if (h == 203) begin
                tests_run++; if (vga_r !== 8'h00) begin tests_failed++; $display("FAIL nf_px: got %h expected 00", vga_r); end
            end
        end
    endtask

    task automatic test_clipping;
        new_frame(1'b1, 600, 50);
        for (int h = 598; h <= 645; h++) begin
            drive_px(h, 50);
            if (h == 600) begin
                tests_run++; if (rom_rd !== 1'b1 || rom_addr !== 15'd0) begin tests_failed++; $display("FAIL clip_start: got rd=%b addr=%0d expected rd=1 addr=0", rom_rd, rom_addr); end
            end
            if (h == 639) begin
                tests_run++; if (rom_rd !== 1'b1 || rom_addr !== 15'd19) begin tests_failed++; $display("FAIL clip_edge: got rd=%b addr=%0d expected rd=1 addr=19", rom_rd, rom_addr); end
            end
            if (h == 640) begin
                tests_run++; if (rom_rd !== 1'b0 || rom_addr !== 15'd19) begin tests_failed++; $display("FAIL clip_off: got rd=%b addr=%0d expected rd=0 addr=19", rom_rd, rom_addr); end
            end
        end
        lines(51, 52);
        for (int h = 600; h <= 639; h++) drive_px(h, 52);
        tests_run++; if (rom_addr !== 15'd179) begin tests_failed++; $display("FAIL clip_row1: got %0d expected 179", rom_addr); end
    endtask

    task automatic test_offscreen_disabled;
        int rd_hits;
        rd_hits = 0;
        new_frame(1'b1, 640, 50);
        for (int h = 600; h <= 700; h++) begin
            drive_px(h, 50);
            if (rom_rd === 1'b1) rd_hits++;
            if (h == 610) begin
                tests_run++; if (vga_r !== 8'h20) begin tests_failed++; $display("FAIL off_bg: got %h expected 20", vga_r); end
            end
        end
        tests_run++; if (rd_hits !== 0) begin tests_failed++; $display("FAIL off_rd: got %0d reads expected 0", rd_hits); end
        rd_hits = 0;
        new_frame(1'b0, 100, 50);
        for (int h = 96; h <= 130; h++) begin
            drive_px(h, 50);
            if (rom_rd === 1'b1) rd_hits++;
            if (h == 110) begin
                tests_run++; if (vga_g !== 8'h20) begin tests_failed++; $display("FAIL dis_bg: got %h expected 20", vga_g); end
            end
        end
        tests_run++; if (rd_hits !== 0) begin tests_failed++; $display("FAIL dis_rd: got %0d reads expected 0", rd_hits); end
    endtask

    task automatic test_reset_midframe;
        int rd_hits;
        rd_hits = 0;
        new_frame(1'b1, 100, 50);
        for (int h = 100; h <= 103; h++) drive_px(h, 50);
        tests_run++; if (rom_rd !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_rd: got %b expected 1", rom_rd); end
        reset_n = 1'b0;
        #1;
        tests_run++; if (rom_rd !== 1'b0 || vga_blank_n !== 1'b0 || vga_hs !== 1'b1 || {vga_r, vga_g, vga_b} !== 24'h000000) begin
            tests_failed++; $display("FAIL rst_async: got rd=%b blank=%b hs=%b rgb=%h expected 0 0 1 000000", rom_rd, vga_blank_n, vga_hs, {vga_r, vga_g, vga_b});
        end
        #2;
        reset_n = 1'b1;
        for (int h = 104; h <= 120; h++) begin
            drive_px(h, 50);
            if (rom_rd === 1'b1) rd_hits++;
        end
        tests_run++; if (rd_hits !== 0) begin tests_failed++; $display("FAIL rst_forced_off: got %0d reads expected 0", rd_hits); end
        tests_run++; if (vga_r !== 8'h20) begin tests_failed++; $display("FAIL rst_bg: got %h expected 20", vga_r); end
        new_frame(1'b1, 100, 50);
        drive_px(100, 50);
        tests_run++; if (rom_rd !== 1'b1 || rom_addr !== 15'd0) begin tests_failed++; $display("FAIL rst_resume: got rd=%b addr=%0d expected rd=1 addr=0", rom_rd, rom_addr); end
    endtask

    initial begin
        test_reset();
        test_frame_start();
        test_latency();
        test_addressing();
        test_color();
        test_midframe_change();
        test_window_end();
        test_next_frame();
        test_clipping();
        test_offscreen_disabled();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
